// File: rtl/capture_trig_writer_if.sv
// RAM port A write bus between the capture front end and the sample RAM.
interface capture_trig_writer_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;

  modport master (output ram_addr, ram_wr_data, ram_wr_en);
  modport slave  (input  ram_addr, ram_wr_data, ram_wr_en);
endinterface

// File: rtl/capture_trig_writer.sv
// Circular-buffer capture writer: pre-trigger window, level/edge/forced trigger,
// post-trigger fill, and oldest-sample address for time-ordered readout.
module capture_trig_writer #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [ADDR_WIDTH-1:0]    pretrig_len,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic                     trig_edge,
  input  logic                     force_trig,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  capture_trig_writer_if.master    ram_a,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    trig_addr,
  output logic [ADDR_WIDTH-1:0]    start_addr
);

  // One extra bit so the post-trigger count can reach the full depth.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_WAIT_TRIG,
    ST_POST_FILL,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [DATA_WIDTH-1:0] lvl_q, lvl_d;
  logic                  edge_q, edge_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  force_pend_q, force_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;

  logic                  edge_hit_c;
  logic [CNT_W-1:0]      post_target_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  wr_c;
  logic                  force_c;

  // Edge detection against the previous valid sample, gated until one exists.
  always_comb begin
    if (trig_edge_sel()) begin
      edge_hit_c = prev_valid_q && (prev_q > lvl_q) && (din <= lvl_q);
    end else begin
      edge_hit_c = prev_valid_q && (prev_q < lvl_q) && (din >= lvl_q);
    end
  end

  function automatic logic trig_edge_sel();
    return edge_q;
  endfunction

  assign post_target_c = DEPTH - {1'b0, pre_q};
  assign cnt_inc_c     = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    lvl_d        = lvl_q;
    edge_d       = edge_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wen_d        = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    wr_c         = 1'b0;
    force_c      = force_pend_q | force_trig;

    if (abort) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      force_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d      = (pretrig_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
            wptr_d       = '0;
            cnt_d        = '0;
            pre_d        = pretrig_len;
            lvl_d        = trig_level;
            edge_d       = trig_edge;
            prev_valid_d = 1'b0;
            force_pend_d = 1'b0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
          end
        end

        // Triggers are not evaluated here so the pre-trigger window always fills.
        ST_PRE_FILL: begin
          if (din_valid) begin
            wr_c = 1'b1;
            if (cnt_inc_c == {1'b0, pre_q}) begin
              state_d = ST_WAIT_TRIG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
        end

        ST_WAIT_TRIG: begin
          if (din_valid) begin
            wr_c = 1'b1;
            if (force_c || edge_hit_c) begin
              trig_addr_d  = wptr_q;
              start_addr_d = wptr_q - pre_q;
              force_pend_d = 1'b0;
              if (post_target_c == CNT_W'(1)) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                state_d = ST_POST_FILL;
                cnt_d   = CNT_W'(1);
              end
            end
          end else begin
            force_pend_d = force_c;
          end
        end

        // The trigger sample counts as the first post-trigger sample.
        ST_POST_FILL: begin
          if (din_valid) begin
            wr_c = 1'b1;
            if (cnt_inc_c == post_target_c) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase

      if (wr_c) begin
        addr_d       = wptr_q;
        data_d       = din;
        wen_d        = 1'b1;
        wptr_d       = wptr_q + ADDR_WIDTH'(1);
        prev_d       = din;
        prev_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      lvl_q        <= '0;
      edge_q       <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wen_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      lvl_q        <= lvl_d;
      edge_q       <= edge_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wen_q        <= wen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign ram_a.ram_addr    = addr_q;
  assign ram_a.ram_wr_data = data_q;
  assign ram_a.ram_wr_en   = wen_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign trig_addr         = trig_addr_q;
  assign start_addr        = start_addr_q;

endmodule
